// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and constants for the multicycle instruction sequencer:
// FSM states, opcode classes, RV32I major opcodes and datapath mux encodings.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR
    } op_class_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic PC_SEL_PLUS4  = 1'b0;
    localparam logic PC_SEL_TARGET = 1'b1;
    localparam logic ADDR_SEL_PC   = 1'b0;
    localparam logic ADDR_SEL_ALU  = 1'b1;

endpackage

// File: rtl/multicycle_sequencer_op_class_decode.sv
// Purely combinational opcode classifier; legal=0 flags any opcode outside
// the supported RV32I major opcode set.
module op_class_decode
    import multicycle_sequencer_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class,
    output logic       legal
);

    always_comb begin
        op_class = CLS_R;
        legal    = 1'b1;
        case (opcode)
            OPC_R:      op_class = CLS_R;
            OPC_I_ALU:  op_class = CLS_I_ALU;
            OPC_LOAD:   op_class = CLS_LOAD;
            OPC_STORE:  op_class = CLS_STORE;
            OPC_BRANCH: op_class = CLS_BRANCH;
            OPC_LUI:    op_class = CLS_LUI;
            OPC_AUIPC:  op_class = CLS_AUIPC;
            OPC_JAL:    op_class = CLS_JAL;
            OPC_JALR:   op_class = CLS_JALR;
            default:    legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB FSM with a memory
// wait-timeout watchdog and a retired-instruction counter.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_sel,
    output logic        reg_write,
    output logic [2:0]  state,
    output logic        halted,
    output logic        timeout_err,
    output logic [31:0] instret
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    op_class_t   class_reg, class_next;
    logic [7:0]  wait_reg, wait_next;
    logic [31:0] instret_reg, instret_next;
    logic        timeout_reg, timeout_next;

    op_class_t   dec_class;
    logic        dec_legal;
    logic        timeout_hit;

    logic mem_req_c, mem_we_c, addr_sel_c, ir_write_c;
    logic pc_write_c, pc_sel_c, reg_write_c, retire;

    op_class_decode u_decode (
        .opcode   (opcode),
        .op_class (dec_class),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_FETCH;
            class_reg   <= CLS_R;
            wait_reg    <= 8'd0;
            instret_reg <= 32'd0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            class_reg   <= class_next;
            wait_reg    <= wait_next;
            instret_reg <= instret_next;
            timeout_reg <= timeout_next;
        end
    end

    // mem_ready on the last allowed wait cycle still completes the request
    assign timeout_hit = mem_req_c && !mem_ready && (wait_reg == WAIT_LAST);

    always_comb begin
        state_next   = state_reg;
        class_next   = class_reg;
        timeout_next = timeout_reg;
        wait_next    = 8'd0;
        instret_next = instret_reg + (retire ? 32'd1 : 32'd0);
        case (state_reg)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_next = ST_DECODE;
                end else if (timeout_hit) begin
                    state_next   = ST_HALT;
                    timeout_next = 1'b1;
                end else begin
                    wait_next = wait_reg + 8'd1;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    class_next = dec_class;
                    state_next = ST_EXEC;
                end else begin
                    state_next = ST_HALT;
                end
            end
            ST_EXEC: begin
                if (class_reg == CLS_BRANCH)
                    state_next = ST_FETCH;
                else if (class_reg == CLS_LOAD || class_reg == CLS_STORE)
                    state_next = ST_MEM;
                else
                    state_next = ST_WB;
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_next = (class_reg == CLS_STORE) ? ST_FETCH : ST_WB;
                end else if (timeout_hit) begin
                    state_next   = ST_HALT;
                    timeout_next = 1'b1;
                end else begin
                    wait_next = wait_reg + 8'd1;
                end
            end
            ST_WB:   state_next = ST_FETCH;
            default: state_next = ST_HALT;
        endcase
    end

    always_comb begin
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        addr_sel_c  = ADDR_SEL_PC;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        pc_sel_c    = PC_SEL_PLUS4;
        reg_write_c = 1'b0;
        retire      = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                mem_req_c  = 1'b1;
                ir_write_c = mem_ready;
            end
            ST_EXEC: begin
                if (class_reg == CLS_BRANCH) begin
                    pc_write_c = 1'b1;
                    pc_sel_c   = br_taken;
                    retire     = 1'b1;
                end
            end
            ST_MEM: begin
                mem_req_c  = 1'b1;
                addr_sel_c = ADDR_SEL_ALU;
                mem_we_c   = (class_reg == CLS_STORE);
                if (mem_ready && class_reg == CLS_STORE) begin
                    pc_write_c = 1'b1;
                    retire     = 1'b1;
                end
            end
            ST_WB: begin
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
                pc_sel_c    = (class_reg == CLS_JAL || class_reg == CLS_JALR) ?
                              PC_SEL_TARGET : PC_SEL_PLUS4;
                retire      = 1'b1;
            end
            default: ;
        endcase
    end

    // reset squashes every strobe immediately, abandoning any in-flight request
    assign mem_req      = mem_req_c   & ~rst;
    assign mem_we       = mem_we_c    & ~rst;
    assign mem_addr_sel = addr_sel_c  & ~rst;
    assign ir_write     = ir_write_c  & ~rst;
    assign pc_write     = pc_write_c  & ~rst;
    assign pc_sel       = pc_sel_c    & ~rst;
    assign reg_write    = reg_write_c & ~rst;

    assign state       = state_reg;
    assign halted      = (state_reg == ST_HALT);
    assign timeout_err = timeout_reg;
    assign instret     = instret_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a cycle-by-cycle vector table for
// ADD/LOAD/STORE/BEQ, then hand sequences for halt, reset, timeout and wrap.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        br_taken;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_write;
    logic        pc_write, pc_sel, reg_write;
    logic [2:0]  state;
    logic        halted, timeout_err;
    logic [31:0] instret;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [6:0] OP_ADD = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    multicycle_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .br_taken     (br_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_sel       (pc_sel),
        .reg_write    (reg_write),
        .state        (state),
        .halted       (halted),
        .timeout_err  (timeout_err),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    // strobe vector order: {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_sel, reg_write}
    typedef struct {
        logic [6:0]  op;
        logic        br;
        logic        rdy;
        logic [2:0]  st;
        logic [6:0]  strb;
        logic [31:0] ir;
    } vec_t;

    vec_t vecs[20];

    function automatic logic [6:0] strobes();
        return {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_sel, reg_write};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic br, input logic rdy);
        opcode    = op;
        br_taken  = br;
        mem_ready = rdy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{OP_ADD, 1'b0, 1'b1, 3'd0, 7'b1001000, 32'd0};
        vecs[1]  = '{OP_ADD, 1'b0, 1'b1, 3'd1, 7'b0000000, 32'd0};
        vecs[2]  = '{OP_ADD, 1'b0, 1'b1, 3'd2, 7'b0000000, 32'd0};
        vecs[3]  = '{OP_ADD, 1'b0, 1'b1, 3'd4, 7'b0000101, 32'd0};
        vecs[4]  = '{OP_LD,  1'b0, 1'b1, 3'd0, 7'b1001000, 32'd1};
        vecs[5]  = '{OP_LD,  1'b0, 1'b1, 3'd1, 7'b0000000, 32'd1};
        vecs[6]  = '{OP_LD,  1'b0, 1'b1, 3'd2, 7'b0000000, 32'd1};
        vecs[7]  = '{OP_LD,  1'b0, 1'b0, 3'd3, 7'b1010000, 32'd1};
        vecs[8]  = '{OP_LD,  1'b0, 1'b0, 3'd3, 7'b1010000, 32'd1};
        vecs[9]  = '{OP_LD,  1'b0, 1'b0, 3'd3, 7'b1010000, 32'd1};
        vecs[10] = '{OP_LD,  1'b0, 1'b1, 3'd3, 7'b1010000, 32'd1};
        vecs[11] = '{OP_LD,  1'b0, 1'b1, 3'd4, 7'b0000101, 32'd1};
        vecs[12] = '{OP_ST,  1'b0, 1'b1, 3'd0, 7'b1001000, 32'd2};
        vecs[13] = '{OP_ST,  1'b0, 1'b1, 3'd1, 7'b0000000, 32'd2};
        vecs[14] = '{OP_BAD, 1'b0, 1'b1, 3'd2, 7'b0000000, 32'd2};
        vecs[15] = '{OP_BAD, 1'b0, 1'b1, 3'd3, 7'b1110100, 32'd2};
        vecs[16] = '{OP_BR,  1'b1, 1'b1, 3'd0, 7'b1001000, 32'd3};
        vecs[17] = '{OP_BR,  1'b1, 1'b1, 3'd1, 7'b0000000, 32'd3};
        vecs[18] = '{OP_ADD, 1'b1, 1'b1, 3'd2, 7'b0000110, 32'd3};
        vecs[19] = '{OP_LUI, 1'b0, 1'b0, 3'd0, 7'b1000000, 32'd4};

        rst = 1'b1; opcode = OP_ADD; br_taken = 1'b0; mem_ready = 1'b0;
        step(); step();
        @(negedge clk);
        check("reset_strobes", 32'(strobes()), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        check("reset_instret", instret, 32'd0);
        check("reset_flags", {30'd0, halted, timeout_err}, 32'd0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].op, vecs[i].br, vecs[i].rdy);
            $display("vec %0d: op=%b rdy=%b st=%0d strb=%b instret=%0d",
                     i, vecs[i].op, vecs[i].rdy, state, strobes(), instret);
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("vec%0d_strobes", i), 32'(strobes()), 32'(vecs[i].strb));
            check($sformatf("vec%0d_instret", i), instret, vecs[i].ir);
            step();
        end

        // illegal opcode: halt from DECODE, not a timeout, instret frozen
        drive(OP_BAD, 1'b0, 1'b1);
        check("illegal_fetch_irw", 32'(ir_write), 32'd1);
        step();
        drive(OP_BAD, 1'b0, 1'b1);
        check("illegal_decode_state", 32'(state), 32'd1);
        step();
        drive(OP_ADD, 1'b0, 1'b1);
        step(); step();
        drive(OP_ADD, 1'b0, 1'b1);
        $display("illegal: state=%0d halted=%b terr=%b instret=%0d", state, halted, timeout_err, instret);
        check("illegal_state", 32'(state), 32'd5);
        check("illegal_flags", {30'd0, halted, timeout_err}, 32'b10);
        check("illegal_strobes", 32'(strobes()), 32'd0);
        check("illegal_instret", instret, 32'd4);
        step();

        // one-cycle reset pulse releases the halt
        do_reset();
        drive(OP_ADD, 1'b0, 1'b0);
        $display("rst pulse: state=%0d halted=%b instret=%0d mem_req=%b", state, halted, instret, mem_req);
        check("pulse_state", 32'(state), 32'd0);
        check("pulse_halted", 32'(halted), 32'd0);
        check("pulse_instret", instret, 32'd0);
        check("pulse_mem_req", 32'(mem_req), 32'd1);
        step();

        // reset asserted mid-request squashes strobes combinationally
        rst = 1'b1;
        drive(OP_ADD, 1'b0, 1'b1);
        $display("rst midreq: strb=%b", strobes());
        check("midreq_strobes", 32'(strobes()), 32'd0);
        step();
        rst = 1'b0;

        // fetch timeout after four unanswered cycles
        for (int c = 0; c < 4; c++) begin
            drive(OP_ADD, 1'b0, 1'b0);
            check($sformatf("to_wait%0d", c), {28'd0, state, mem_req}, 32'b0001);
            step();
        end
        drive(OP_ADD, 1'b0, 1'b1);
        $display("timeout: state=%0d halted=%b terr=%b", state, halted, timeout_err);
        check("to_state", 32'(state), 32'd5);
        check("to_flags", {30'd0, halted, timeout_err}, 32'b11);
        check("to_mem_req", 32'(mem_req), 32'd0);
        step();
        drive(OP_ADD, 1'b0, 1'b1);
        check("to_sticky", {28'd0, state, halted}, {28'd0, 3'd5, 1'b1});
        step();

        // ready on the last allowed cycle wins; JAL retirement wraps instret
        do_reset();
        force dut.instret_reg = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            drive(OP_JAL, 1'b0, 1'b0);
            step();
            if (c == 0) release dut.instret_reg;
        end
        drive(OP_JAL, 1'b0, 1'b1);
        check("race_irw", 32'(ir_write), 32'd1);
        check("preload_instret", instret, 32'hFFFF_FFFF);
        step();
        drive(OP_JAL, 1'b0, 1'b0);
        $display("race: state=%0d halted=%b", state, halted);
        check("race_state", 32'(state), 32'd1);
        check("race_halted", 32'(halted), 32'd0);
        step();
        drive(OP_ADD, 1'b0, 1'b0);
        check("jal_exec_strobes", 32'(strobes()), 32'd0);
        step();
        drive(OP_ADD, 1'b0, 1'b0);
        $display("jal wb: state=%0d strb=%b", state, strobes());
        check("jal_wb_state", 32'(state), 32'd4);
        check("jal_wb_strobes", 32'(strobes()), 32'b0000111);
        step();
        drive(OP_ADD, 1'b0, 1'b0);
        $display("jal wrap: instret=0x%0h state=%0d", instret, state);
        check("wrap_instret", instret, 32'd0);
        check("wrap_state", 32'(state), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
